// File: rtl/word_scan_display_pkg.sv
// ---------------------------------------------------------------------------
// word_scan_display_pkg
//   Shared definitions for the word scan display block:
//   - fetch FSM state encoding
//   - display geometry (number of hex digits) and the blank segment pattern
//   - hex-to-7-segment lookup table, bit order gfedcba, active-low
// ---------------------------------------------------------------------------
package word_scan_display_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    localparam int         NUM_DIGITS = 8;
    localparam int         DIGIT_W    = $clog2(NUM_DIGITS);
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Indexed by nibble value; entry 15 is listed first in the concatenation.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/word_scan_display_hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
//   Combinational nibble to 7-segment decoder.
//   Ports:
//     nibble  in  4  hex value to display
//     segs    out 7  segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex7seg
    import word_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = HEX7_TABLE[nibble];

endmodule

// File: rtl/word_scan_display.sv
// ---------------------------------------------------------------------------
// word_scan_display
//   Fetches the 32-bit word at addr_in from a synchronous-read memory and
//   shows it as 8 hex digits on a multiplexed, active-low 7-segment display.
//   Ports:
//     clk          in  1   system clock, rising edge
//     rst          in  1   asynchronous, active-high reset
//     addr_in      in  4   address from the upstream counter (sync to clk)
//     mem_rd_addr  out 4   registered read address to memory
//     mem_rd_data  in  32  read data, valid RD_LAT cycles after mem_rd_addr
//     shown_addr   out 4   address of the word currently displayed
//     an           out 8   digit enables, active-low, an[0] = rightmost
//     seg          out 8   {dp,g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module word_scan_display
    import word_scan_display_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int DIV_COUNT = 100000,
    parameter int DIV_W     = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr_in,
    output logic [3:0]  mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic [3:0]  shown_addr,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam logic [2:0]       LAT_TGT  = 3'(RD_LAT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    state_t       state_q, state_d;
    logic [3:0]   rd_addr_d;
    logic [2:0]   lat_cnt, lat_cnt_d;
    logic [31:0]  word_q, word_d;
    logic [3:0]   shown_d;
    logic         valid, valid_d;

    // NOTE: every signal gets its hold value first so no path through the
    // case leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = mem_rd_addr;
        lat_cnt_d = lat_cnt;
        word_d    = word_q;
        shown_d   = shown_addr;
        valid_d   = valid;
        case (state_q)
            S_IDLE: begin
                // valid==0 forces a first fetch even when addr_in matches.
                if (!valid || (addr_in != mem_rd_addr)) begin
                    rd_addr_d = addr_in;
                    lat_cnt_d = '0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                if (addr_in != mem_rd_addr) begin
                    // Address moved during the read: abandon it and restart.
                    rd_addr_d = addr_in;
                    lat_cnt_d = '0;
                end else if (lat_cnt == LAT_TGT) begin
                    word_d  = mem_rd_data;
                    shown_d = mem_rd_addr;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_rd_addr <= '0;
            lat_cnt     <= '0;
            word_q      <= '0;
            shown_addr  <= '0;
            valid       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_rd_addr <= rd_addr_d;
            lat_cnt     <= lat_cnt_d;
            word_q      <= word_d;
            shown_addr  <= shown_d;
            valid       <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit scanner: free-running from reset, independent of valid
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]   prescaler;
    logic [DIGIT_W-1:0] digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            digit     <= '0;
        end else if (prescaler == DIV_LAST) begin
            prescaler <= '0;
            digit     <= digit + 1'b1;   // wraps 7 -> 0 by width
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Display: one shared decoder, muxed by digit, registered outputs
    // ------------------------------------------------------------------
    logic [3:0] cur_nibble;
    logic [6:0] cur_segs;

    assign cur_nibble = word_q[{digit, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (cur_nibble),
        .segs   (cur_segs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
        end else if (valid) begin
            an  <= ~(8'b1 << digit);     // exactly one enable low
            seg <= {1'b1, cur_segs};     // dp held off
        end else begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_word_scan_display.sv
module tb_word_scan_display;

    localparam int DIVC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  addr_in = 4'd0;

    logic [3:0]  a1, s1, a3, s3;
    logic [31:0] d1, d3, q1, q2, q3;
    logic [7:0]  an1, seg1, an3, seg3;

    logic [31:0] mem [16];
    int          n_edges;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Memory models: 1-cycle and 3-cycle synchronous read.
    always @(posedge clk) begin
        d1 <= mem[a1];
        q1 <= mem[a3];
        q2 <= q1;
        q3 <= q2;
    end
    assign d3 = q3;

    // Edges since reset release: reference timebase for the scanner.
    always @(posedge clk or posedge rst) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    word_scan_display #(.RD_LAT(1), .DIV_COUNT(DIVC), .DIV_W(3)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .mem_rd_addr(a1),
        .mem_rd_data(d1), .shown_addr(s1), .an(an1), .seg(seg1)
    );

    word_scan_display #(.RD_LAT(3), .DIV_COUNT(DIVC), .DIV_W(3)) dut3 (
        .clk(clk), .rst(rst), .addr_in(addr_in), .mem_rd_addr(a3),
        .mem_rd_data(d3), .shown_addr(s3), .an(an3), .seg(seg3)
    );

    function automatic logic [6:0] hex7_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the scanning display against the reference timebase and word w.
    task automatic scan(input string tag, input logic [31:0] w, input int cycles, input bit use3);
        int         d;
        logic [7:0] ea, es;
        for (int i = 0; i < cycles; i++) begin
            tick();
            d  = ((n_edges - 1) / DIVC) % 8;
            ea = ~(8'b1 << d);
            es = {1'b1, hex7_ref(w[4*d +: 4])};
            check({tag, "_an"},  use3 ? an3 : an1,   ea);
            check({tag, "_seg"}, use3 ? seg3 : seg1, es);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[2]  = 32'h0246_8ACE;
        mem[3]  = 32'h0BAD_F00D;
        mem[4]  = 32'hDEAD_BEEF;
        mem[5]  = 32'h1234_ABCD;
        mem[6]  = 32'h9876_5F10;
        mem[9]  = 32'hC0FF_EE17;
        mem[15] = 32'hFFFF_FFFF;

        // ---- reset state ----
        repeat (2) tick();
        check("rst_an", an1, 8'hFF);
        check("rst_seg", seg1, 8'hFF);
        check("rst_shown", s1, 4'd0);
        check("rst_rdaddr", a1, 4'd0);

        // ---- boot fetch at address 0 ----
        rst = 1'b0;
        tick();  check("boot_e1_rdaddr", a1, 4'd0);  check("boot_e1_an", an1, 8'hFF);
        tick();  check("boot_e2_an", an1, 8'hFF);
        tick();  check("boot_e3_shown", s1, 4'd0);   check("boot_e3_an", an1, 8'hFF);
        scan("boot", 32'h0, 36, 1'b0);

        // ---- 0 -> 5, both latencies ----
        addr_in = 4'd5;
        tick();  check("w5_e1_rdaddr", a1, 4'd5); check("w5_e1_shown", s1, 4'd0); check("w5_e1_shown3", s3, 4'd0);
        tick();  check("w5_e2_shown", s1, 4'd0);
        tick();  check("w5_e3_shown", s1, 4'd5);  check("w5_e3_shown3", s3, 4'd0);
        tick();  check("w5_e4_shown3", s3, 4'd0);
        tick();  check("w5_e5_shown3", s3, 4'd5);
        scan("w5", 32'h1234_ABCD, 34, 1'b0);
        scan("w5_lat3", 32'h1234_ABCD, 34, 1'b1);

        // ---- abandoned read: 3 -> 4 -> 6 on consecutive cycles ----
        addr_in = 4'd3;
        repeat (6) tick();
        check("ab_shown3", s1, 4'd3);
        addr_in = 4'd4;
        tick();  check("ab_k1_rdaddr", a1, 4'd4);
        addr_in = 4'd6;
        tick();  check("ab_k2_rdaddr", a1, 4'd6); check("ab_k2_shown", s1, 4'd3);
        tick();  check("ab_k3_shown", s1, 4'd3);
        tick();  check("ab_k4_shown", s1, 4'd6);
        scan("w6", 32'h9876_5F10, 34, 1'b0);

        // ---- wrap 15 -> 0 ----
        addr_in = 4'd15;
        repeat (3) tick();
        check("wrap_shown15", s1, 4'd15);
        scan("w15", 32'hFFFF_FFFF, 34, 1'b0);
        mem[0]  = 32'h8888_8888;
        addr_in = 4'd0;
        tick();  tick();  check("wrap_e2_shown", s1, 4'd15);
        tick();  check("wrap_e3_shown0", s1, 4'd0);
        scan("w0", 32'h8888_8888, 34, 1'b0);

        // ---- asynchronous reset mid-read ----
        addr_in = 4'd9;
        repeat (8) tick();
        check("pre_rst_shown9", s1, 4'd9);
        addr_in = 4'd2;
        tick();  check("mid_rdaddr", a1, 4'd2);
        #2 rst = 1'b1;
        #1;
        check("async_an", an1, 8'hFF);
        check("async_seg", seg1, 8'hFF);
        check("async_shown", s1, 4'd0);
        check("async_rdaddr", a1, 4'd0);
        check("async_an3", an3, 8'hFF);
        repeat (2) tick();
        rst = 1'b0;
        tick();  check("rel_e1_rdaddr", a1, 4'd2); check("rel_e1_an", an1, 8'hFF);
        tick();
        tick();  check("rel_e3_shown", s1, 4'd2);  check("rel_e3_an", an1, 8'hFF);
        scan("post_rst", 32'h0246_8ACE, 34, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
